// File: rtl/serial_deser_if.sv
// Bundle of the 4-wire serial bus pins and the packet/status side of serial_deser.
// The master modport is the side that drives the pins and consumes packets.
interface serial_deser_if #(
  parameter int PACKET_WIDTH = 9
);
  logic                    sd;
  logic                    cs;
  logic                    sck;
  logic                    rs;
  logic                    valid;
  logic                    ready;
  logic [PACKET_WIDTH-1:0] data;
  logic                    overflow;
  logic                    frame_err;
  logic                    err_clr;
  logic                    busy;

  modport master (
    output sd, cs, sck, rs, ready, err_clr,
    input  valid, data, overflow, frame_err, busy
  );

  modport slave (
    input  sd, cs, sck, rs, ready, err_clr,
    output valid, data, overflow, frame_err, busy
  );
endinterface

// File: rtl/serial_deser.sv
// Oversampling receiver for the LCD serial link: rebuilds {rs, word} packets
// from sd/cs/sck/rs and queues them in a small FIFO behind a valid/ready port.
module serial_deser #(
  parameter int WORD_WIDTH   = 8,
  parameter int PACKET_WIDTH = 9,
  parameter int SYNC_STAGES  = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input logic          clk,
  input logic          rst,
  serial_deser_if.slave bus
);

  localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  // Synchronizer chains; the *_s view is the last stage.
  logic [SYNC_STAGES-1:0] sd_sync, sck_sync, rs_sync, cs_sync;
  logic sd_s, sck_s, rs_s, cs_s;
  logic sd_d, sck_d, rs_d, cs_d;

  logic [WORD_WIDTH-1:0]   shift_reg;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    frame_err_q;
  logic                    overflow_q;

  logic [PACKET_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr;

  logic fall, abort, push, pop, empty, full, wr_en, ovf_set;
  logic [PACKET_WIDTH-1:0] packet;

  assign sd_s  = sd_sync[SYNC_STAGES-1];
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign rs_s  = rs_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];

  // cs flops reset to 1 so a held-low cs pin at reset release looks like a fresh select.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sd_sync  <= '0;
      sck_sync <= '0;
      rs_sync  <= '0;
      cs_sync  <= '1;
      sd_d     <= 1'b0;
      sck_d    <= 1'b0;
      rs_d     <= 1'b0;
      cs_d     <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, which is what turns these lines into a shift chain.
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], bus.sd};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      rs_sync  <= {rs_sync[SYNC_STAGES-2:0], bus.rs};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
      sd_d     <= sd_s;
      sck_d    <= sck_s;
      rs_d     <= rs_s;
      cs_d     <= cs_s;
    end
  end

  // sd_d/rs_d still hold the value seen while sck was high, i.e. mid-bit.
  assign fall   = sck_d & ~sck_s & ~cs_s;
  assign abort  = cs_s & ~cs_d & (bit_cnt != '0);
  assign push   = fall & (bit_cnt == LAST_BIT);
  assign packet = {rs_d, shift_reg[WORD_WIDTH-2:0], sd_d};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= abort;
      if (cs_s) begin
        bit_cnt <= '0;
        if (abort) shift_reg <= '0;
      end else if (fall) begin
        shift_reg <= {shift_reg[WORD_WIDTH-2:0], sd_d};
        bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop   = ~empty & bus.ready;

  // A push into a full FIFO survives only if the head leaves in the same cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    wr_en   = 1'b0;
    ovf_set = 1'b0;
    if (push) begin
      if (!full || pop) wr_en   = 1'b1;
      else              ovf_set = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
      // NOTE: the storage is reset on purpose: the head is visible on data
      // and must read 0 out of reset; with only a few entries this is cheap.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= packet;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)          overflow_q <= 1'b1;
      else if (bus.err_clr) overflow_q <= 1'b0;
    end
  end

  assign bus.valid     = ~empty;
  assign bus.data      = mem[rd_ptr[AW-1:0]];
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = ~cs_s | (bit_cnt != '0);

endmodule

// File: tb/tb_serial_deser.sv
// Directed bench for serial_deser: a table of single-word frames plus hand-written
// sequences for back-to-back, overflow, pop-on-full, abort and mid-word reset.
module tb_serial_deser;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   fe_count = 0;

  serial_deser_if #(.PACKET_WIDTH(9)) bus ();

  serial_deser #(
    .WORD_WIDTH(8), .PACKET_WIDTH(9), .SYNC_STAGES(2), .FIFO_DEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.frame_err === 1'b1) fe_count++;

  typedef struct {
    logic       rs;
    logic [7:0] word;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.sd  = b;
    bus.sck = 1'b1;
    repeat (4) @(negedge clk);
    bus.sck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Sends one word MSB first. lat = clk edges from the last sck fall until valid
  // is seen high; with pop_on_push, ready is raised exactly for the push edge.
  task automatic send_word(input logic rs_v, input logic [7:0] w,
                           input bit pop_on_push, output int lat);
    bus.rs = rs_v;
    for (int i = 7; i > 0; i--) send_bit(w[i]);
    bus.sd  = w[0];
    bus.sck = 1'b1;
    repeat (4) @(negedge clk);
    bus.sck = 1'b0;
    lat = 0;
    if (pop_on_push) begin
      repeat (2) @(negedge clk);
      check("head_at_push", 32'(bus.data), 32'h001);
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
      repeat (3) @(negedge clk);
    end else begin
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        lat++;
        if (bus.valid === 1'b1) break;
      end
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic cs_low();
    bus.cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    bus.cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic pop_expect(input string name, input logic [8:0] exp);
    int t = 0;
    while (bus.valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.valid !== 1'b1) begin
      check({name, "_valid_timeout"}, 32'(bus.valid), 32'h1);
    end else begin
      check(name, 32'(bus.data), 32'(exp));
      bus.ready = 1'b1;
      @(negedge clk);
      bus.ready = 1'b0;
    end
  endtask

  initial begin
    int lat;
    int fe_before;

    vecs[0] = '{1'b1, 8'hA5, 9'h1A5};
    vecs[1] = '{1'b0, 8'h2A, 9'h02A};
    vecs[2] = '{1'b1, 8'h00, 9'h100};
    vecs[3] = '{1'b1, 8'hEF, 9'h1EF};
    vecs[4] = '{1'b0, 8'h3C, 9'h03C};
    vecs[5] = '{1'b1, 8'hFF, 9'h1FF};
    vecs[6] = '{1'b0, 8'h81, 9'h081};

    rst = 1'b0;
    bus.sd = 1'b0; bus.cs = 1'b1; bus.sck = 1'b0; bus.rs = 1'b0;
    bus.ready = 1'b0; bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(bus.valid), 32'h0);
    check("rst_data", 32'(bus.data), 32'h0);
    check("rst_overflow", 32'(bus.overflow), 32'h0);
    check("rst_frame_err", 32'(bus.frame_err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Single-word frames: latency, packet value, no frame_err.
    for (int v = 0; v < 7; v++) begin
      fe_before = fe_count;
      cs_low();
      check("busy_selected", 32'(bus.busy), 32'h1);
      send_word(vecs[v].rs, vecs[v].word, 1'b0, lat);
      check($sformatf("latency_%0d", v), 32'(lat), 32'd3);
      cs_high();
      check($sformatf("no_frame_err_%0d", v), 32'(fe_count - fe_before), 32'd0);
      pop_expect($sformatf("vec_%0d", v), vecs[v].exp);
      check($sformatf("empty_after_%0d", v), 32'(bus.valid), 32'h0);
    end

    // Back-to-back words under one cs.
    cs_low();
    send_word(1'b0, 8'h2A, 1'b0, lat);
    send_word(1'b1, 8'h00, 1'b0, lat);
    send_word(1'b1, 8'hEF, 1'b0, lat);
    cs_high();
    check("b2b_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    check("b2b_busy", 32'(bus.busy), 32'h0);
    pop_expect("b2b_0", 9'h02A);
    pop_expect("b2b_1", 9'h100);
    pop_expect("b2b_2", 9'h1EF);

    // Overflow: five words into four entries with ready low.
    cs_low();
    for (int i = 1; i <= 5; i++) send_word(1'b0, 8'(i), 1'b0, lat);
    cs_high();
    check("ovf_set", 32'(bus.overflow), 32'h1);
    for (int i = 1; i <= 4; i++) pop_expect($sformatf("ovf_drain_%0d", i), 9'(i));
    check("ovf_empty", 32'(bus.valid), 32'h0);
    check("ovf_sticky", 32'(bus.overflow), 32'h1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'h0);

    // Full FIFO with a pop landing on the fifth push edge.
    cs_low();
    for (int i = 1; i <= 4; i++) send_word(1'b0, 8'(i), 1'b0, lat);
    send_word(1'b0, 8'h05, 1'b1, lat);
    cs_high();
    check("popfull_no_ovf", 32'(bus.overflow), 32'h0);
    for (int i = 2; i <= 5; i++) pop_expect($sformatf("popfull_%0d", i), 9'(i));
    check("popfull_empty", 32'(bus.valid), 32'h0);

    // Abort after three bits, then a clean word.
    fe_before = fe_count;
    cs_low();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    cs_high();
    check("abort_pulse_count", 32'(fe_count - fe_before), 32'd1);
    check("abort_no_push", 32'(bus.valid), 32'h0);
    check("abort_bit_cnt", 32'(dut.bit_cnt), 32'd0);
    cs_low();
    send_word(1'b0, 8'h3C, 1'b0, lat);
    cs_high();
    pop_expect("after_abort", 9'h03C);

    // Reset in the middle of a word.
    fe_before = fe_count;
    cs_low();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_valid", 32'(bus.valid), 32'h0);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    check("midrst_data", 32'(bus.data), 32'h0);
    check("midrst_overflow", 32'(bus.overflow), 32'h0);
    repeat (3) @(negedge clk);
    check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    send_word(1'b1, 8'h81, 1'b0, lat);
    cs_high();
    check("midrst_no_frame_err", 32'(fe_count - fe_before), 32'd0);
    pop_expect("midrst_word", 9'h181);
    repeat (4) @(negedge clk);
    check("midrst_single", 32'(bus.valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_deser.md
# serial_deser

Receive-side counterpart of the LCD serial link. It oversamples the 4-wire serial bus (sd, cs, sck, rs) in its own clock domain and rebuilds {rs, word} packets. It then delivers them through a small FIFO on a valid/ready port. Uses: loopback checking of the LCD transmitter on hardware, a bus monitor, and a readback path for display-side serial data.

## Interface
- WORD_WIDTH, 8, data bits per word, shifted MSB first.
- PACKET_WIDTH, 9, output packet width; must equal WORD_WIDTH+1 (bit PACKET_WIDTH-1 = rs).
- SYNC_STAGES, 2, synchronizer depth for sd, cs, sck, rs; minimum 2.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.

- clk  in  1  sampling clock; must run at least 4x the sck frequency.
- rst  in  1  reset, asynchronous, active-low.
- sd  in  1  serial data, asynchronous to clk.
- cs  in  1  chip select, active-low, asynchronous.
- sck  in  1  serial clock; idles low when cs is high.
- rs  in  1  register select (1 = data, 0 = command), stable for the whole word.
- valid  out  1  FIFO head holds a packet.
- ready  in  1  consumer accepts the head this cycle.
- data  out  PACKET_WIDTH  {rs, word} at the FIFO head.
- overflow  out  1  sticky: a completed packet was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: cs deasserted with a partial word.
- err_clr  in  1  synchronous clear of overflow.
- busy  out  1  synchronized cs low or bit count nonzero.

## Operation
- Synchronizers: sd, cs, sck and rs each pass through SYNC_STAGES flops (*_s outputs).
- Alignment flops: one further flop each produces sck_d, sd_d, rs_d and cs_d.
- fall strobe = sck_d & ~sck_s & ~cs_s.
- The sample is taken from sd_d/rs_d, i.e. the value while sck was still high. The transmitter launches on the sck rising edge, so sd is mid-bit at this point.
- On each fall strobe:
  - shift_reg <= {shift_reg[WORD_WIDTH-2:0], sd_d}.
  - bit_cnt increments, modulo WORD_WIDTH.
- When the strobe arrives with bit_cnt == WORD_WIDTH-1:
  - form packet {rs_d, shift_reg[WORD_WIDTH-2:0], sd_d}.
  - push it into the FIFO.
  - bit_cnt wraps to 0.
- cs may stay low across words; the next word starts on the next strobe with no idle cycle.
- Abort: cs_s high while cs_d low (rising cs) and bit_cnt != 0:
  - frame_err pulses for one cycle.
  - bit_cnt clears; shift contents are discarded.
  - No push.
- While cs_s is high, bit_cnt is held at 0. A rising cs with bit_cnt == 0 is a clean end of frame: no pulse.
- FIFO:
  - Read/write pointers carry an extra wrap bit. empty = pointers equal; full = indices equal and wrap bits differ.
  - valid = ~empty; data = mem[rd_idx].
  - Pop occurs when valid & ready.
- Push when full:
  - If a pop happens the same cycle, the push is accepted: no loss, no overflow.
  - Otherwise the packet is dropped and overflow is set.
- Push and pop on an empty FIFO in the same cycle: the push is accepted, and the pop is not possible because valid is low.
- overflow clears on err_clr. If a set and a clear land in the same cycle, the set wins.
- Reset values: valid=0, data=0, overflow=0, frame_err=0, busy=0. FIFO is emptied, bit_cnt=0, shift_reg=0, all synchronizer flops=0, and the cs flops reset to 1 (deselected).
- Reset asserted mid-word: everything clears immediately (asynchronous); the partial word is lost and no frame_err is raised.

## Timing
- Edge N is the first clk edge that captures the pin change into sync stage 1.
- The fall strobe is high in the cycle after edge N+SYNC_STAGES-1.
- Shift and push occur on edge N+SYNC_STAGES. valid is high immediately after that edge if the FIFO was empty.
- Latency from the last-bit sck fall to valid is SYNC_STAGES+1 clk edges, including edge N.
- frame_err uses the same latency relative to the cs rise and is high for exactly one clk cycle.
- data is stable while valid & ~ready. Throughput is one pop per cycle.
- sck high and low phases must each span at least 2 clk periods. Narrower pulses may be missed and are outside the spec.

## Test plan
- Single packet: cs low, rs=1, 8 sck cycles carrying 0xA5, cs high → exactly one packet data=0x1A5; valid rises SYNC_STAGES+1 edges after the last fall; no frame_err.
- Back-to-back frame: cs held low, words cmd 0x2A, data 0x00, data 0xEF → packets 0x02A, 0x100, 0x1EF in order; bit_cnt back at 0 and busy=0 after cs rises.
- Overflow: ready=0, send 5 words 0x01..0x05 → FIFO holds 0x001..0x004, overflow=1; draining returns those four; err_clr → overflow=0.
- Full with simultaneous pop: FIFO full and ready=1 during the 5th push cycle → no overflow; 0x005 delivered after 0x004.
- Abort: cs rises after 3 bits → frame_err high for 1 cycle, no push; the next full word 0x3C with rs=0 yields 0x03C.
- Reset mid-word: rst low after 4 bits, then released, then a full word 0x81 with rs=1 → only 0x181 delivered; all outputs at reset values during reset.
